// File: rtl/ac97_link_rx_if.sv
// Signal bundle for the AC97 receive link: the controller-driven serial pair
// plus every field the receiver recovers from a committed frame.
interface ac97_link_rx_if #(parameter int SAMPLE_BITS = 16);
  logic                   sync;
  logic                   sdata;
  logic [15:0]            tag;
  logic [SAMPLE_BITS-1:0] pcm_left;
  logic [SAMPLE_BITS-1:0] pcm_right;
  logic                   pcm_valid;
  logic                   cmd_read;
  logic [6:0]             cmd_addr;
  logic [15:0]            cmd_data;
  logic                   cmd_valid;
  logic                   frame_valid;
  logic [15:0]            frame_count;
  logic                   locked;
  logic                   sync_error;

  modport master (
    output sync, sdata,
    input  tag, pcm_left, pcm_right, pcm_valid, cmd_read, cmd_addr, cmd_data,
           cmd_valid, frame_valid, frame_count, locked, sync_error
  );

  modport slave (
    input  sync, sdata,
    output tag, pcm_left, pcm_right, pcm_valid, cmd_read, cmd_addr, cmd_data,
           cmd_valid, frame_valid, frame_count, locked, sync_error
  );
endinterface

// File: rtl/ac97_link_rx.sv
// AC97 link receiver: aligns to sync, deserializes the tag, command slots and
// playback slots of each 256-bit frame, and publishes them one cycle after bit 255.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_HUNT  | unaligned; waiting for a sampled low-to-high transition on sync
// S_TAG   | receiving tag bits 0-15, sync must be high
// S_SLOTS | receiving slot bits 16-255, sync must be low
module ac97_link_rx #(
  parameter int SAMPLE_BITS = 16
) (
  input  logic          clk,
  input  logic          reset,
  ac97_link_rx_if.slave link
);

  localparam logic [1:0] S_HUNT  = 2'd0;
  localparam logic [1:0] S_TAG   = 2'd1;
  localparam logic [1:0] S_SLOTS = 2'd2;
  localparam int SB = SAMPLE_BITS;

  logic [1:0]    r_state;
  logic [7:0]    r_bit_cnt;
  logic          r_prev_sync;
  logic [18:0]   r_shift;
  logic          r_commit_pend;

  logic [15:0]   r_stg_tag;
  logic          r_stg_read;
  logic [6:0]    r_stg_addr;
  logic [15:0]   r_stg_data;
  logic [SB-1:0] r_stg_left;
  logic [SB-1:0] r_stg_right;

  logic [15:0]   r_tag;
  logic [SB-1:0] r_pcm_left;
  logic [SB-1:0] r_pcm_right;
  logic          r_pcm_valid;
  logic          r_cmd_read;
  logic [6:0]    r_cmd_addr;
  logic [15:0]   r_cmd_data;
  logic          r_cmd_valid;
  logic          r_frame_valid;
  logic [15:0]   r_frame_count;
  logic          r_locked;
  logic          r_sync_error;

  logic [7:0]    w_idx;
  logic [19:0]   w_word;
  logic          w_rise;
  logic          w_err;

  // r_bit_cnt holds the index of the last accepted bit; w_idx is the bit being sampled now.
  assign w_idx  = r_bit_cnt + 8'd1;
  assign w_word = {r_shift, link.sdata};
  assign w_rise = ~r_prev_sync & link.sync;
  assign w_err  = ((r_state == S_TAG) & ~link.sync) | ((r_state == S_SLOTS) & link.sync);

  // Framing and staging; staged fields are only copied to the outputs at commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_HUNT;
      r_bit_cnt     <= '0;
      r_prev_sync   <= 1'b0;
      r_shift       <= '0;
      r_commit_pend <= 1'b0;
      r_stg_tag     <= '0;
      r_stg_read    <= 1'b0;
      r_stg_addr    <= '0;
      r_stg_data    <= '0;
      r_stg_left    <= '0;
      r_stg_right   <= '0;
      r_sync_error  <= 1'b0;
    end else begin
      r_prev_sync   <= link.sync;
      r_sync_error  <= w_err;
      r_commit_pend <= 1'b0;
      case (r_state)
        S_HUNT: begin
          if (w_rise) begin
            r_state   <= S_TAG;
            r_bit_cnt <= 8'd0;
            r_shift   <= w_word[18:0];
          end
        end
        S_TAG: begin
          if (w_err) begin
            r_state <= S_HUNT;
          end else begin
            r_shift   <= w_word[18:0];
            r_bit_cnt <= w_idx;
            if (w_idx == 8'd15) begin
              r_stg_tag <= w_word[15:0];
              r_state   <= S_SLOTS;
            end
          end
        end
        S_SLOTS: begin
          if (w_err) begin
            r_state <= S_HUNT;
          end else begin
            r_shift   <= w_word[18:0];
            r_bit_cnt <= w_idx;
            case (w_idx)
              8'd35: begin
                r_stg_read <= w_word[19];
                r_stg_addr <= w_word[18:12];
              end
              8'd55:  r_stg_data  <= w_word[19:4];
              8'd75:  r_stg_left  <= w_word[19 -: SB];
              8'd95:  r_stg_right <= w_word[19 -: SB];
              8'd255: begin
                r_commit_pend <= 1'b1;
                r_state       <= S_TAG;
              end
              default: ;
            endcase
          end
        end
        default: r_state <= S_HUNT;
      endcase
    end
  end

  // Commit lands on the same edge that checks the next bit 0, so a gap error
  // and the commit pulse share a cycle and the error wins on locked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag         <= '0;
      r_pcm_left    <= '0;
      r_pcm_right   <= '0;
      r_pcm_valid   <= 1'b0;
      r_cmd_read    <= 1'b0;
      r_cmd_addr    <= '0;
      r_cmd_data    <= '0;
      r_cmd_valid   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_count <= '0;
      r_locked      <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_pcm_valid   <= 1'b0;
      if (r_commit_pend) begin
        r_tag         <= r_stg_tag;
        r_frame_valid <= 1'b1;
        r_frame_count <= r_frame_count + 16'd1;
        r_locked      <= 1'b1;
        if (r_stg_tag[15] & r_stg_tag[14]) begin
          r_cmd_read  <= r_stg_read;
          r_cmd_addr  <= r_stg_addr;
          r_cmd_valid <= 1'b1;
          if (r_stg_tag[13])
            r_cmd_data <= r_stg_data;
        end
        if (r_stg_tag[15] & (r_stg_tag[12] | r_stg_tag[11])) begin
          r_pcm_valid <= 1'b1;
          if (r_stg_tag[12])
            r_pcm_left <= r_stg_left;
          if (r_stg_tag[11])
            r_pcm_right <= r_stg_right;
        end
      end
      if (w_err)
        r_locked <= 1'b0;
    end
  end

  assign link.tag         = r_tag;
  assign link.pcm_left    = r_pcm_left;
  assign link.pcm_right   = r_pcm_right;
  assign link.pcm_valid   = r_pcm_valid;
  assign link.cmd_read    = r_cmd_read;
  assign link.cmd_addr    = r_cmd_addr;
  assign link.cmd_data    = r_cmd_data;
  assign link.cmd_valid   = r_cmd_valid;
  assign link.frame_valid = r_frame_valid;
  assign link.frame_count = r_frame_count;
  assign link.locked      = r_locked;
  assign link.sync_error  = r_sync_error;

endmodule

// File: tb/tb_ac97_link_rx.sv
// Self-checking bench for ac97_link_rx: serial frames are built bit by bit and
// the observed pulse events are compared against a frame-level reference model.
module tb_ac97_link_rx;
  localparam int SB = 16;
  localparam int EW = 4 + 16 + 2*SB + 1 + 7 + 16 + 16 + 1;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ac97_link_rx_if #(.SAMPLE_BITS(SB)) link ();
  ac97_link_rx #(.SAMPLE_BITS(SB)) dut (.clk(clk), .reset(reset), .link(link));

  typedef struct {
    int            idx;
    logic          fv, se, cv, pv;
    logic [15:0]   tag;
    logic [SB-1:0] pl, pr;
    logic          crd;
    logic [6:0]    cad;
    logic [15:0]   cdt, cnt;
    logic          lk;
  } ev_t;

  logic [1:0] stim[$];
  ev_t obs[$];
  ev_t exp_q[$];

  logic [15:0]   m_tag, m_cdt, m_cnt;
  logic [SB-1:0] m_pl, m_pr;
  logic          m_crd;
  logic [6:0]    m_cad;

  function automatic void model_reset();
    m_tag = '0; m_cdt = '0; m_cnt = '0; m_pl = '0; m_pr = '0; m_crd = 1'b0; m_cad = '0;
  endfunction

  // Frame-level commit rules: tag always, command on 15&14, PCM on 15&(12|11).
  function automatic void model_commit(input logic [15:0] tg, input logic [19:0] s1, s2, s3, s4,
                                       output logic cv, output logic pv);
    cv = 1'b0; pv = 1'b0;
    m_tag = tg;
    m_cnt = m_cnt + 16'd1;
    if (tg[15] && tg[14]) begin
      m_crd = s1[19];
      m_cad = s1[18:12];
      if (tg[13]) m_cdt = s2[19:4];
      cv = 1'b1;
    end
    if (tg[15] && (tg[12] || tg[11])) begin
      if (tg[12]) m_pl = s3[19 -: SB];
      if (tg[11]) m_pr = s4[19 -: SB];
      pv = 1'b1;
    end
  endfunction

  function automatic void expect_ev(input int idx, input logic fv, se, cv, pv, lk);
    ev_t e;
    e.idx = idx; e.fv = fv; e.se = se; e.cv = cv; e.pv = pv; e.lk = lk;
    e.tag = m_tag; e.pl = m_pl; e.pr = m_pr; e.crd = m_crd; e.cad = m_cad; e.cdt = m_cdt; e.cnt = m_cnt;
    exp_q.push_back(e);
  endfunction

  function automatic logic [EW-1:0] pack_ev(input ev_t e);
    return {e.fv, e.se, e.cv, e.pv, e.tag, e.pl, e.pr, e.crd, e.cad, e.cdt, e.cnt, e.lk};
  endfunction

  function automatic logic [19:0] rnd20();
    return 20'($urandom);
  endfunction

  function automatic logic [15:0] rnd_tag();
    logic [15:0] t;
    t = 16'($urandom);
    if ($urandom_range(0, 3) != 0) t[15] = 1'b1;
    return t;
  endfunction

  // drop < 16: sync falls early at that tag bit; drop >= 16: one-bit sync glitch in the slots.
  function automatic void add_frame(input logic [15:0] tg, input logic [19:0] s1, s2, s3, s4,
                                    input int drop);
    logic [19:0] sl [1:12];
    sl[1] = s1; sl[2] = s2; sl[3] = s3; sl[4] = s4;
    for (int n = 5; n <= 12; n++) sl[n] = rnd20();
    for (int b = 0; b < 256; b++) begin
      logic sy;
      logic d;
      int   n;
      int   k;
      sy = (b < 16);
      n  = (b - 16) / 20 + 1;
      k  = (b - 16) % 20;
      if (b < 16) d = tg[15 - b];
      else        d = sl[n][19 - k];
      if (drop >= 0 && drop < 16 && b >= drop && b < 16) sy = 1'b0;
      if (drop >= 16 && b == drop) sy = 1'b1;
      stim.push_back({sy, d});
    end
  endfunction

  function automatic void add_idle(input int n);
    repeat (n) stim.push_back(2'b00);
  endfunction

  // Observes at each falling edge (before driving element i) and records any pulse.
  task automatic drive_stream();
    int n;
    n = stim.size();
    obs.delete();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (link.frame_valid || link.sync_error || link.cmd_valid || link.pcm_valid) begin
        ev_t e;
        e.idx = i; e.fv = link.frame_valid; e.se = link.sync_error; e.cv = link.cmd_valid;
        e.pv = link.pcm_valid; e.tag = link.tag; e.pl = link.pcm_left; e.pr = link.pcm_right;
        e.crd = link.cmd_read; e.cad = link.cmd_addr; e.cdt = link.cmd_data;
        e.cnt = link.frame_count; e.lk = link.locked;
        obs.push_back(e);
      end
      if (i < n) begin
        link.sync  = stim[i][1];
        link.sdata = stim[i][0];
      end
    end
    stim.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; link.sync = 1'b0; link.sdata = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    checks++;
    if ({link.tag, link.pcm_left, link.pcm_right, link.pcm_valid, link.cmd_read, link.cmd_addr,
         link.cmd_data, link.cmd_valid, link.frame_valid, link.frame_count, link.locked,
         link.sync_error} !== '0) begin
      errors++; $display("FAIL reset_outputs: tag %h count %h locked %b, want all zero",
                         link.tag, link.frame_count, link.locked);
    end
    @(negedge clk);
    reset = 1'b1;
    add_idle(1000);
    drive_stream();
    checks++;
    if (obs.size() != 0) begin
      errors++; $display("FAIL idle_pulses: got %0d pulse events, want 0", obs.size());
    end
    checks++;
    if ({link.locked, link.frame_count, link.tag, link.pcm_left} !== '0) begin
      errors++; $display("FAIL idle_outputs: locked %b count %h tag %h, want zero",
                         link.locked, link.frame_count, link.tag);
    end
  endtask

  task automatic test_single_frame_and_gap();
    logic cv, pv;
    add_frame(16'h9800, rnd20(), rnd20(), 20'hABCD0, 20'h12340, -1);
    add_frame(16'h0000, rnd20(), rnd20(), rnd20(), rnd20(), -1);
    add_idle(20);
    model_commit(16'h9800, 20'h0, 20'h0, 20'hABCD0, 20'h12340, cv, pv);
    model_commit(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0, cv, pv);
    drive_stream();
    checks++;
    if (obs.size() != 2) begin
      errors++; $display("FAIL single_event_count: got %0d, want 2", obs.size());
    end
    if (obs.size() >= 1) begin
      checks++;
      if (obs[0].idx != 257) begin
        errors++; $display("FAIL commit_latency: got index %0d, want 257", obs[0].idx);
      end
      checks++;
      if ({obs[0].fv, obs[0].pv, obs[0].cv, obs[0].se, obs[0].lk} !== 5'b11001) begin
        errors++; $display("FAIL single_pulses: got fv/pv/cv/se/lk %b%b%b%b%b, want 11001",
                           obs[0].fv, obs[0].pv, obs[0].cv, obs[0].se, obs[0].lk);
      end
      checks++;
      if (obs[0].pl !== 16'hABCD || obs[0].pr !== 16'h1234 || obs[0].cnt !== 16'd1) begin
        errors++; $display("FAIL single_data: got L %h R %h count %0d, want ABCD 1234 1",
                           obs[0].pl, obs[0].pr, obs[0].cnt);
      end
    end
    if (obs.size() >= 2) begin
      checks++;
      if (obs[1].idx != 513 || {obs[1].fv, obs[1].se, obs[1].lk} !== 3'b110 || obs[1].cnt !== 16'd2) begin
        errors++; $display("FAIL gap_commit: got idx %0d fv/se/lk %b%b%b count %0d, want 513 110 2",
                           obs[1].idx, obs[1].fv, obs[1].se, obs[1].lk, obs[1].cnt);
      end
    end
  endtask

  task automatic test_command();
    logic cv, pv;
    logic [19:0] s1b;
    s1b = rnd20();
    add_frame(16'hE000, 20'h82000, 20'h55AA0, rnd20(), rnd20(), -1);
    add_frame(16'hC000, s1b, rnd20(), rnd20(), rnd20(), -1);
    add_idle(20);
    model_commit(16'hE000, 20'h82000, 20'h55AA0, 20'h0, 20'h0, cv, pv);
    model_commit(16'hC000, s1b, 20'h0, 20'h0, 20'h0, cv, pv);
    drive_stream();
    checks++;
    if (obs.size() != 2) begin
      errors++; $display("FAIL cmd_event_count: got %0d, want 2", obs.size());
    end
    if (obs.size() >= 1) begin
      checks++;
      if ({obs[0].crd, obs[0].cad, obs[0].cdt} !== {1'b1, 7'h02, 16'h55AA}) begin
        errors++; $display("FAIL cmd_fields: got rd %b addr %h data %h, want 1 02 55AA",
                           obs[0].crd, obs[0].cad, obs[0].cdt);
      end
      checks++;
      if ({obs[0].fv, obs[0].cv, obs[0].pv} !== 3'b110 || obs[0].pl !== 16'hABCD || obs[0].pr !== 16'h1234) begin
        errors++; $display("FAIL cmd_pcm_hold: got fv/cv/pv %b%b%b L %h R %h, want 110 ABCD 1234",
                           obs[0].fv, obs[0].cv, obs[0].pv, obs[0].pl, obs[0].pr);
      end
    end
    if (obs.size() >= 2) begin
      checks++;
      if (obs[1].cdt !== 16'h55AA || obs[1].cad !== s1b[18:12] || obs[1].crd !== s1b[19] || obs[1].cv !== 1'b1) begin
        errors++; $display("FAIL cmd_data_hold: got addr %h data %h cv %b, want %h 55AA 1",
                           obs[1].cad, obs[1].cdt, obs[1].cv, s1b[18:12]);
      end
    end
  endtask

  task automatic test_short_sync();
    logic cv, pv;
    logic [15:0] t [4];
    logic [19:0] s [4][4];
    for (int f = 0; f < 4; f++) begin
      t[f] = rnd_tag();
      for (int j = 0; j < 4; j++) s[f][j] = rnd20();
      add_frame(t[f], s[f][0], s[f][1], s[f][2], s[f][3], (f == 1) ? 10 : -1);
    end
    add_idle(20);
    exp_q.delete();
    model_commit(t[0], s[0][0], s[0][1], s[0][2], s[0][3], cv, pv); expect_ev(257, 1, 0, cv, pv, 1);
    expect_ev(267, 0, 1, 0, 0, 0);
    model_commit(t[2], s[2][0], s[2][1], s[2][2], s[2][3], cv, pv); expect_ev(769, 1, 0, cv, pv, 1);
    model_commit(t[3], s[3][0], s[3][1], s[3][2], s[3][3], cv, pv); expect_ev(1025, 1, 1, cv, pv, 0);
    drive_stream();
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("FAIL short_sync_count: got %0d events, want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].idx != exp_q[i].idx || pack_ev(obs[i]) !== pack_ev(exp_q[i])) begin
        errors++; $display("FAIL short_sync_ev%0d: got idx %0d %h, want idx %0d %h",
                           i, obs[i].idx, pack_ev(obs[i]), exp_q[i].idx, pack_ev(exp_q[i]));
      end
    end
  endtask

  task automatic test_slot_errors();
    logic cv, pv;
    logic [15:0] td;
    logic [19:0] sd [4];
    td = rnd_tag();
    for (int j = 0; j < 4; j++) sd[j] = rnd20();
    add_frame(rnd_tag(), rnd20(), rnd20(), rnd20(), rnd20(), 100);
    add_frame(rnd_tag(), rnd20(), rnd20(), rnd20(), rnd20(), 255);
    add_frame(rnd_tag(), rnd20(), rnd20(), rnd20(), rnd20(), -1);
    add_frame(td, sd[0], sd[1], sd[2], sd[3], -1);
    add_idle(20);
    exp_q.delete();
    expect_ev(101, 0, 1, 0, 0, 0);
    expect_ev(512, 0, 1, 0, 0, 0);
    model_commit(td, sd[0], sd[1], sd[2], sd[3], cv, pv); expect_ev(1025, 1, 1, cv, pv, 0);
    drive_stream();
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("FAIL slot_err_count: got %0d events, want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].idx != exp_q[i].idx || pack_ev(obs[i]) !== pack_ev(exp_q[i])) begin
        errors++; $display("FAIL slot_err_ev%0d: got idx %0d %h, want idx %0d %h",
                           i, obs[i].idx, pack_ev(obs[i]), exp_q[i].idx, pack_ev(exp_q[i]));
      end
    end
  endtask

  task automatic test_slot4_invalid();
    logic cv, pv;
    logic [19:0] s3b;
    s3b = rnd20();
    add_frame(16'h9800, rnd20(), rnd20(), 20'h0F0F0, 20'h12340, -1);
    add_frame(16'h9000, rnd20(), rnd20(), s3b, 20'h99990, -1);
    add_frame(16'h7800, rnd20(), rnd20(), rnd20(), rnd20(), -1);
    add_idle(20);
    model_commit(16'h9800, 20'h0, 20'h0, 20'h0F0F0, 20'h12340, cv, pv);
    model_commit(16'h9000, 20'h0, 20'h0, s3b, 20'h99990, cv, pv);
    model_commit(16'h7800, 20'h0, 20'h0, 20'h0, 20'h0, cv, pv);
    drive_stream();
    checks++;
    if (obs.size() != 3) begin
      errors++; $display("FAIL slot4_event_count: got %0d, want 3", obs.size());
    end
    if (obs.size() >= 2) begin
      checks++;
      if (obs[1].pr !== 16'h1234 || obs[1].pl !== s3b[19:4] || obs[1].pv !== 1'b1) begin
        errors++; $display("FAIL slot4_hold: got L %h R %h pv %b, want %h 1234 1",
                           obs[1].pl, obs[1].pr, obs[1].pv, s3b[19:4]);
      end
    end
    if (obs.size() >= 3) begin
      checks++;
      if ({obs[2].fv, obs[2].pv, obs[2].cv} !== 3'b100 || obs[2].pl !== s3b[19:4] || obs[2].tag !== 16'h7800) begin
        errors++; $display("FAIL frame_invalid_tag: got fv/pv/cv %b%b%b L %h tag %h, want 100 %h 7800",
                           obs[2].fv, obs[2].pv, obs[2].cv, obs[2].pl, obs[2].tag, s3b[19:4]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic cv, pv;
    logic [15:0] tg;
    logic [19:0] s [4];
    exp_q.delete();
    for (int f = 0; f < 8; f++) begin
      tg = rnd_tag();
      for (int j = 0; j < 4; j++) s[j] = rnd20();
      add_frame(tg, s[0], s[1], s[2], s[3], -1);
      model_commit(tg, s[0], s[1], s[2], s[3], cv, pv);
      expect_ev(257 + 256*f, 1, (f == 7), cv, pv, (f != 7));
    end
    add_idle(20);
    drive_stream();
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d events, want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].idx != exp_q[i].idx || pack_ev(obs[i]) !== pack_ev(exp_q[i])) begin
        errors++; $display("FAIL b2b_ev%0d: got idx %0d %h, want idx %0d %h",
                           i, obs[i].idx, pack_ev(obs[i]), exp_q[i].idx, pack_ev(exp_q[i]));
      end
    end
  endtask

  task automatic test_mid_reset();
    logic cv, pv;
    logic [19:0] s3;
    add_frame(16'h9800, rnd20(), rnd20(), rnd20(), rnd20(), -1);
    while (stim.size() > 150) void'(stim.pop_back());
    drive_stream();
    @(negedge clk);
    reset = 1'b0;
    link.sync = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs.size() != 0 || link.sync_error !== 1'b0 || link.frame_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_pulses: got %0d events se %b fv %b, want none",
                         obs.size(), link.sync_error, link.frame_valid);
    end
    checks++;
    if ({link.tag, link.pcm_left, link.pcm_right, link.cmd_data, link.frame_count, link.locked} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: tag %h L %h count %h, want zero",
                         link.tag, link.pcm_left, link.frame_count);
    end
    reset = 1'b1;
    model_reset();
    s3 = rnd20();
    add_frame(16'h9000, rnd20(), rnd20(), s3, rnd20(), -1);
    add_idle(20);
    model_commit(16'h9000, 20'h0, 20'h0, s3, 20'h0, cv, pv);
    drive_stream();
    checks++;
    if (obs.size() != 1) begin
      errors++; $display("FAIL post_reset_count: got %0d, want 1", obs.size());
    end else begin
      checks++;
      if (obs[0].cnt !== 16'd1 || obs[0].pl !== m_pl || obs[0].pr !== '0 || obs[0].idx != 257) begin
        errors++; $display("FAIL post_reset_frame: got idx %0d count %0d L %h R %h, want 257 1 %h 0",
                           obs[0].idx, obs[0].cnt, obs[0].pl, obs[0].pr, m_pl);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    link.sync = 1'b0;
    link.sdata = 1'b0;
    test_reset();
    test_single_frame_and_gap();
    test_command();
    test_short_sync();
    test_slot_errors();
    test_slot4_invalid();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
